// File: rtl/divmod.sv
// divmod: sequential unsigned divider producing quotient and remainder.
// Radix-4 restoring division: one quotient digit (2 bits) per BUSY cycle.
//
// Parameters:
//   WIDTH  operand/result width (even, >= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   go     start request; accepted in IDLE or DONE, ignored in BUSY
//   a, b   dividend / divisor, latched when go is accepted
//   ready  high in DONE; div/mod/error hold the last result
//   error  high with ready when the last divisor was zero
//   div    quotient floor(a/b), all ones on divide by zero
//   mod    remainder a - b*div, equal to a on divide by zero
//
// Optional build macro: DIVMOD_EARLY_EXIT_EN
//   When defined, a < b finishes one cycle after accept, and leading
//   all-zero 2-bit pairs of the dividend are skipped. Results are unchanged;
//   latency never exceeds WIDTH/2+1.
//
// state | meaning
// IDLE  | after reset, outputs zero, waiting for go
// BUSY  | iterating (cnt_q digits remain; cnt_q == 0 means publish)
// DONE  | result valid on div/mod/error, ready high, waiting for go

module divmod #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] mod
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH+1:0] b2_q, b2_d;
  logic [WIDTH+1:0] b3_q, b3_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             err_q, err_d;

  // One radix-4 step. The partial remainder is always < b, so after
  // shifting in two dividend bits it needs WIDTH+2 bits; after the
  // subtraction it is < b again and fits back into WIDTH bits.
  logic [WIDTH+1:0] trial;
  logic [1:0]       digit;
  logic [WIDTH-1:0] rem_nx;

  always_comb begin
    trial  = {rem_q, shf_q[WIDTH-1 -: 2]};
    digit  = 2'd0;
    rem_nx = rem_q;
    if (trial >= b3_q) begin
      digit  = 2'd3;
      rem_nx = WIDTH'(trial - b3_q);
    end else if (trial >= b2_q) begin
      digit  = 2'd2;
      rem_nx = WIDTH'(trial - b2_q);
    end else if (trial >= {2'b00, b_q}) begin
      digit  = 2'd1;
      rem_nx = WIDTH'(trial - {2'b00, b_q});
    end else begin
      digit  = 2'd0;
      rem_nx = trial[WIDTH-1:0];
    end
  end

`ifdef DIVMOD_EARLY_EXIT_EN
  // Count leading all-zero 2-bit pairs of the incoming dividend.
  int  lz;
  logic seen;

  always_comb begin
    lz   = 0;
    seen = 1'b0;
    for (int i = HALF - 1; i >= 0; i--) begin
      if (!seen) begin
        if (a[2*i +: 2] == 2'b00) lz = lz + 1;
        else seen = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mod_d   = mod_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = BUSY;
          a_d     = a;
          b_d     = b;
          b2_d    = {1'b0, b, 1'b0};
          b3_d    = {2'b00, b} + {1'b0, b, 1'b0};
          rem_d   = '0;
          quo_d   = '0;
          err_d   = 1'b0;
`ifdef DIVMOD_EARLY_EXIT_EN
          shf_d   = a << (2 * lz);
          cnt_d   = CW'(HALF - lz);
`else
          shf_d   = a;
          cnt_d   = CW'(HALF);
`endif
        end
      end

      BUSY: begin
        if (b_q == '0) begin
          state_d = DONE;
          err_d   = 1'b1;
          div_d   = '1;
          mod_d   = a_q;
        end
`ifdef DIVMOD_EARLY_EXIT_EN
        else if (a_q < b_q) begin
          state_d = DONE;
          div_d   = '0;
          mod_d   = a_q;
        end
`endif
        else if (cnt_q == '0) begin
          state_d = DONE;
          div_d   = quo_q;
          mod_d   = rem_q;
        end else begin
          rem_d = rem_nx;
          quo_d = (quo_q << 2) | WIDTH'(digit);
          shf_d = shf_q << 2;
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      b2_q    <= '0;
      b3_q    <= '0;
      rem_q   <= '0;
      shf_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      mod_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mod_q   <= mod_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == DONE);
  assign error = err_q;
  assign div   = div_q;
  assign mod   = mod_q;

endmodule

// File: tb/tb_divmod.sv
// tb_divmod: directed bench for divmod. A reference model built from plain
// division and a cycle count since accept predicts ready and the results;
// one negedge process compares the DUT against it every cycle.

module tb_divmod;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         ready;
  logic         error;
  logic [W-1:0] div;
  logic [W-1:0] mod;

  divmod #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .a     (a_i),
    .b     (b_i),
    .ready (ready),
    .error (error),
    .div   (div),
    .mod   (mod)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit           m_active = 1'b0;
  int           m_acc    = 0;
  int           m_lat    = 0;
  logic [W-1:0] m_div    = '0;
  logic [W-1:0] m_mod    = '0;
  logic         m_err    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    int k;
    if (!rst) begin
      if (!m_active) begin
        chk("idle_outputs", {ready, error, div, mod}, '0);
      end else begin
        k = cyc - m_acc;
`ifdef DIVMOD_EARLY_EXIT_EN
        if (k >= m_lat) chk("ready_level", ready, 1'b1);
        if (ready) chk("result", {error, div, mod}, {m_err, m_div, m_mod});
`else
        chk("ready_level", ready, (k >= m_lat));
        if (ready && k >= m_lat) chk("result", {error, div, mod}, {m_err, m_div, m_mod});
`endif
      end
    end
  end

  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    go  = 1'b1;
    a_i = av;
    b_i = bv;
    @(posedge clk);
    #1;
    go       = 1'b0;
    m_active = 1'b1;
    m_acc    = cyc;
    if (bv == '0) begin
      m_lat = 1;
      m_err = 1'b1;
      m_div = '1;
      m_mod = av;
    end else begin
      m_lat = W / 2 + 1;
      m_err = 1'b0;
      m_div = av / bv;
      m_mod = av % bv;
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 30 && !ready; n++) begin
      @(posedge clk);
      #1;
    end
    if (!ready) begin
      chk("ready_timeout", ready, 1'b1);
    end else begin
`ifdef DIVMOD_EARLY_EXIT_EN
      chk("latency_bound", ((cyc - m_acc) <= m_lat), 1'b1);
`else
      chk("latency", cyc - m_acc, m_lat);
`endif
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    start(av, bv);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "tb_divmod timeout");
  end

  initial begin
    logic [W-1:0] av, bv;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", {ready, error, div, mod}, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", {ready, error, div, mod}, '0);

    for (int x = 0; x < 20; x++) begin
      for (int y = 1; y < 20; y++) begin
        av = W'(x);
        bv = W'(y);
        run_op(av, bv);
      end
    end

    run_op(16'd17, 16'd5);
    chk("lit_17_5", {error, div, mod}, {1'b0, 16'd3, 16'd2});

    run_op(16'd7, 16'd0);
    chk("lit_div0", {ready, error, div, mod}, {1'b1, 1'b1, 16'hFFFF, 16'd7});
    run_op(16'd7, 16'd2);
    chk("lit_after_div0", {error, div, mod}, {1'b0, 16'd3, 16'd1});

    run_op(16'hFFFF, 16'hFFFF);
    chk("lit_ffff_ffff", {div, mod}, {16'd1, 16'd0});
    run_op(16'hFFFF, 16'd3);
    chk("lit_ffff_3", {div, mod}, {16'h5555, 16'd0});
    run_op(16'h8000, 16'hFFFF);
    chk("lit_8000_ffff", {div, mod}, {16'd0, 16'h8000});
    run_op(16'hFFFF, 16'd1);
    chk("lit_ffff_1", {div, mod}, {16'hFFFF, 16'd0});
    run_op(16'd1000, 16'd37);
    chk("lit_1000_37", {div, mod}, {16'd27, 16'd1});

    // go while busy must be ignored and input changes must not matter
    start(16'd100, 16'd7);
    repeat (2) @(posedge clk);
    #1;
    go  = 1'b1;
    a_i = 16'd5;
    b_i = 16'd1;
    @(posedge clk);
    #1;
    go  = 1'b0;
    a_i = 16'hAAAA;
    b_i = 16'h0003;
    wait_done();
    chk("lit_busy_protect", {error, div, mod}, {1'b0, 16'd14, 16'd2});

    // reset in the middle of an operation
    start(16'd50, 16'd3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid_op", {ready, error, div, mod}, '0);
    m_active = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_op(16'd50, 16'd3);
    chk("lit_after_reset", {error, div, mod}, {1'b0, 16'd16, 16'd2});

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
